dcache_load_responder: RTL and testbench

- Cache-side responder for the load buffer's read port. Accepts one outstanding load request (rd_cache/addr/mem_size) and looks it up in a direct-mapped, read-only data cache with 64-bit lines.
- On a miss, fetches the line from main memory over the tagged proc2mem/mem2proc interface.
- Returns the size-extracted, sign- or zero-extended 32-bit value to the load buffer with a one-cycle cache_valid pulse.

---
 rtl/dcache_load_responder.sv | 170 +++++++++++++++++
 tb/tb_dcache_load_responder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_load_responder.sv
// Direct-mapped, read-only data cache answering one load-buffer request at a time.
// A miss fetches the 64-bit line over the tagged proc2mem/mem2proc interface.
// Optional: define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_load_responder #(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned MEM_TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_cache,
  input  logic [31:0]          addr,
  input  logic [2:0]           mem_size,
  output logic                 cache_valid,
  output logic [31:0]          cache_data,
  output logic [1:0]           proc2mem_command,
  output logic [31:0]          proc2mem_addr,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = 29 - IdxW;
  localparam logic [1:0] CmdNone = 2'd0;
  localparam logic [1:0] CmdLoad = 2'd1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [MEM_TAG_W-1:0]  mem_tag_q, mem_tag_d;
  logic [NUM_LINES-1:0]  line_valid_q;
  logic [TagW-1:0]       line_tag_q  [NUM_LINES];
  logic [63:0]           line_data_q [NUM_LINES];
  logic                  cache_valid_q, cache_valid_d;
  logic [31:0]           cache_data_q, cache_data_d;

  logic [2:0]            offset;
  logic [IdxW-1:0]       index;
  logic [TagW-1:0]       req_tag;
  logic                  hit;
  logic                  fill;
  logic [63:0]           src_line;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [31:0]           word_val;

  assign offset  = addr[2:0];
  assign index   = addr[3 +: IdxW];
  assign req_tag = addr[31 -: TagW];
  assign hit     = line_valid_q[index] && (line_tag_q[index] == req_tag);
  // A zero saved tag never matches, so stale returns after reset are ignored.
  assign fill    = (state_q == StWait) && (mem_tag_q != '0) && (mem2proc_tag == mem_tag_q);

  // Size extraction and sign/zero extension from either the stored or the arriving line.
  always_comb begin
    src_line     = (state_q == StWait) ? mem2proc_data : line_data_q[index];
    byte_val     = src_line[{offset, 3'b000} +: 8];
    half_val     = src_line[{offset[2:1], 4'b0000} +: 16];
    word_val     = src_line[{offset[2], 5'b00000} +: 32];
    cache_data_d = word_val;
    case (mem_size[1:0])
      2'd0:    cache_data_d = {{24{~mem_size[2] & byte_val[7]}}, byte_val};
      2'd1:    cache_data_d = {{16{~mem_size[2] & half_val[15]}}, half_val};
      default: cache_data_d = word_val;
    endcase
  end

  // Next-state, memory command and response-strobe logic.
  always_comb begin
    state_d          = state_q;
    mem_tag_d        = mem_tag_q;
    cache_valid_d    = 1'b0;
    proc2mem_command = CmdNone;
    proc2mem_addr    = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (rd_cache) begin
          if (hit) begin
            state_d       = StResp;
            cache_valid_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        proc2mem_command = CmdLoad;
        proc2mem_addr    = {addr[31:3], 3'b000};
        if (mem2proc_response != '0) begin
          mem_tag_d = mem2proc_response;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (fill) begin
          mem_tag_d     = '0;
          cache_valid_d = rd_cache;
          state_d       = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM, outstanding tag and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      mem_tag_q     <= '0;
      cache_valid_q <= 1'b0;
      cache_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      mem_tag_q     <= mem_tag_d;
      cache_valid_q <= cache_valid_d;
      if (cache_valid_d) begin
        cache_data_q <= cache_data_d;
      end
    end
  end

  // Line valid bits; the only cache state that reset must clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_valid_q <= '0;
    end else if (fill) begin
      line_valid_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays; a fill replaces whatever occupied the index.
  always_ff @(posedge clock) begin
    if (fill) begin
      line_tag_q[index]  <= req_tag;
      line_data_q[index] <= mem2proc_data;
    end
  end

  assign cache_valid = cache_valid_q;
  assign cache_data  = cache_data_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Saturating lookup counters, bumped when IDLE resolves a request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else if (state_q == StIdle) begin
      if (state_d == StResp && hit_count_q != 32'hFFFF_FFFF) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (state_d == StReq && miss_count_q != 32'hFFFF_FFFF) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_load_responder.sv
// Randomized self-checking bench for dcache_load_responder with a line-level cache model.
module tb_dcache_load_responder;

  localparam int NumLines = 32;

  logic        clock, reset, rd_cache;
  logic [31:0] addr;
  logic [2:0]  mem_size;
  logic        cache_valid;
  logic [31:0] cache_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_load_responder #(.NUM_LINES(NumLines), .MEM_TAG_W(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .rd_cache          (rd_cache),
    .addr              (addr),
    .mem_size          (mem_size),
    .cache_valid       (cache_valid),
    .cache_data        (cache_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  bit in_resp = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [63:0] mem [int unsigned];
  bit          ref_valid [NumLines];
  logic [31:0] ref_line  [NumLines];

  function automatic logic [63:0] get_line(logic [31:0] la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom};
    return mem[la];
  endfunction

  // Aligned n-byte field containing the offset, then extend by mem_size[2].
  function automatic logic [31:0] ref_extract(logic [63:0] line, logic [2:0] off, logic [2:0] sz);
    int n;
    int start;
    logic [63:0] mask;
    logic [63:0] raw;
    n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    start = (int'(off) / n) * n;
    mask = (64'd1 << (8 * n)) - 64'd1;
    raw = (line >> (8 * start)) & mask;
    if (!sz[2] && raw[8 * n - 1]) raw = raw | ~mask;
    return raw[31:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NumLines; i++) ref_valid[i] = 0;
    in_resp = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic recover();
    rd_cache = 0;
    mem2proc_response = 0;
    mem2proc_tag = 0;
    #2 reset = 0;
    #2 reset = 1;
    step();
    clear_model();
  endtask

  task automatic idle();
    rd_cache = 0;
    if (in_resp) begin
      step();
      checks++;
      if (cache_valid !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: cache_valid=%b want 0", cache_valid);
      end
      in_resp = 0;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] sz, input int rejects,
                         input logic [3:0] tg, input logic [3:0] decoy, output bit missed);
    logic [31:0] la;
    int idx;
    bit exp_hit;
    bit early;
    int loads;
    logic [63:0] line;
    logic [31:0] exp;
    la = {a[31:3], 3'b000};
    idx = int'((a >> 3) % NumLines);
    exp_hit = ref_valid[idx] && (ref_line[idx] == la);
    line = get_line(la);
    exp = ref_extract(line, a[2:0], sz);
    missed = !exp_hit;
    rd_cache = 1;
    addr = a;
    mem_size = sz;
    if (in_resp) begin
      step();
      checks++;
      if (cache_valid !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: cache_valid=%b want 0", cache_valid);
      end
      in_resp = 0;
    end
    step();
    if (exp_hit) begin
      exp_hits++;
      checks++;
      if (cache_valid !== 1'b1 || cache_data !== exp || proc2mem_command !== 2'd0) begin
        errors++;
        $display("FAIL hit_resp @%h: valid=%b data=%h cmd=%0d want valid=1 data=%h cmd=0",
                 a, cache_valid, cache_data, proc2mem_command, exp);
        recover();
        return;
      end
      pulse_cyc = cyc;
      in_resp = 1;
      return;
    end
    exp_misses++;
    checks++;
    if (proc2mem_command !== 2'd1 || proc2mem_addr !== la || cache_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_req @%h: cmd=%0d maddr=%h valid=%b want cmd=1 maddr=%h valid=0",
               a, proc2mem_command, proc2mem_addr, cache_valid, la);
      recover();
      return;
    end
    loads = 1;
    early = 0;
    for (int r = 0; r < rejects; r++) begin
      mem2proc_response = 0;
      step();
      if (proc2mem_command === 2'd1 && proc2mem_addr === la) loads++;
      if (cache_valid !== 1'b0) early = 1;
    end
    mem2proc_response = tg;
    step();
    mem2proc_response = 0;
    checks++;
    if (loads != rejects + 1 || proc2mem_command !== 2'd0) begin
      errors++;
      $display("FAIL load_hold @%h: load cycles=%0d cmd_after=%0d want %0d and 0",
               a, loads, proc2mem_command, rejects + 1);
      recover();
      return;
    end
    if (decoy != 0 && decoy != tg) begin
      mem2proc_tag = decoy;
      mem2proc_data = ~line;
      step();
      mem2proc_tag = 0;
      if (cache_valid !== 1'b0) early = 1;
    end
    for (int w = $urandom_range(0, 2); w > 0; w--) begin
      step();
      if (cache_valid !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL early_pulse @%h: cache_valid seen before fill, want none", a);
    end
    mem2proc_tag = tg;
    mem2proc_data = line;
    step();
    mem2proc_tag = 0;
    mem2proc_data = 0;
    ref_valid[idx] = 1;
    ref_line[idx] = la;
    checks++;
    if (cache_valid !== 1'b1 || cache_data !== exp) begin
      errors++;
      $display("FAIL fill_resp @%h: valid=%b data=%h want valid=1 data=%h",
               a, cache_valid, cache_data, exp);
      recover();
      return;
    end
    pulse_cyc = cyc;
    in_resp = 1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (cache_valid !== 1'b0 || cache_data !== 32'h0 || proc2mem_command !== 2'd0 ||
        proc2mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h cmd=%0d maddr=%h want all 0",
               cache_valid, cache_data, proc2mem_command, proc2mem_addr);
    end
    #3 reset = 1;
    step();
  endtask

  task automatic test_cold_miss();
    bit m;
    mem[32'h100] = 64'h8899AABB_CCDDEEFF;
    do_load(32'h104, 3'b010, 0, 4'd3, 4'd0, m);
    checks++;
    if (!m || cache_data !== 32'h8899AABB) begin
      errors++;
      $display("FAIL cold_miss: missed=%b data=%h want 1 8899aabb", m, cache_data);
    end
  endtask

  task automatic test_hit();
    bit m;
    do_load(32'h105, 3'b000, 0, 4'd1, 4'd0, m);
    checks++;
    if (m || cache_data !== 32'hFFFFFFAA) begin
      errors++;
      $display("FAIL hit_sbyte: missed=%b data=%h want 0 ffffffaa", m, cache_data);
    end
    do_load(32'h106, 3'b101, 0, 4'd1, 4'd0, m);
    checks++;
    if (m || cache_data !== 32'h00008899) begin
      errors++;
      $display("FAIL hit_uhalf: missed=%b data=%h want 0 00008899", m, cache_data);
    end
  endtask

  task automatic test_back_to_back();
    bit m;
    int c1;
    do_load(32'h101, 3'b100, 0, 4'd1, 4'd0, m);
    c1 = pulse_cyc;
    do_load(32'h102, 3'b001, 0, 4'd1, 4'd0, m);
    checks++;
    if (pulse_cyc - c1 != 2) begin
      errors++;
      $display("FAIL back_to_back: pulse spacing=%0d want 2", pulse_cyc - c1);
    end
    idle();
  endtask

  task automatic test_reject();
    bit m;
    do_load(32'h2A4, 3'b110, 3, 4'd5, 4'd2, m);
    checks++;
    if (!m) begin
      errors++;
      $display("FAIL reject_miss: missed=%b want 1", m);
    end
    idle();
  endtask

  task automatic test_eviction();
    bit m1, m2, m3;
    logic [31:0] far;
    far = 32'h100 + 8 * NumLines;
    do_load(32'h100, 3'b010, 0, 4'd6, 4'd0, m1);
    do_load(far, 3'b010, 1, 4'd7, 4'd0, m2);
    do_load(32'h100, 3'b010, 0, 4'd8, 4'd0, m3);
    checks++;
    if (m1 || !m2 || !m3) begin
      errors++;
      $display("FAIL eviction: missed=%b%b%b want 011", m1, m2, m3);
    end
    idle();
  endtask

  task automatic test_reset_wait();
    bit m;
    bit late;
    idle();
    rd_cache = 1;
    addr = 32'h3C4;
    mem_size = 3'b010;
    void'(get_line(32'h3C0));
    step();
    mem2proc_response = 4'd7;
    step();
    mem2proc_response = 0;
    step();
    #2 reset = 0;
    #1;
    checks++;
    if (cache_valid !== 1'b0 || cache_data !== 32'h0 || proc2mem_command !== 2'd0 ||
        proc2mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h cmd=%0d maddr=%h want all 0",
               cache_valid, cache_data, proc2mem_command, proc2mem_addr);
    end
    rd_cache = 0;
    #1 reset = 1;
    clear_model();
    step();
    late = 0;
    mem2proc_tag = 4'd7;
    mem2proc_data = mem[32'h3C0];
    step();
    if (cache_valid !== 1'b0) late = 1;
    mem2proc_tag = 0;
    step();
    if (cache_valid !== 1'b0) late = 1;
    checks++;
    if (late) begin
      errors++;
      $display("FAIL late_tag: cache_valid pulsed after reset, want 0");
    end
    do_load(32'h3C4, 3'b010, 0, 4'd4, 4'd0, m);
    checks++;
    if (!m) begin
      errors++;
      $display("FAIL reset_refill: missed=%b want 1", m);
    end
    idle();
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    bit m;
    recover();
    do_load(32'h100, 3'b010, 0, 4'd3, 4'd0, m);
    do_load(32'h104, 3'b010, 0, 4'd3, 4'd0, m);
    do_load(32'h100, 3'b000, 0, 4'd3, 4'd0, m);
    idle();
    checks++;
    if (miss_count !== 32'd1 || hit_count !== 32'd2) begin
      errors++;
      $display("FAIL stats: miss=%0d hit=%0d want 1 2", miss_count, hit_count);
    end
  endtask
`endif

  task automatic test_random();
    bit m;
    logic [31:0] a;
    logic [3:0] tg;
    logic [3:0] dc;
    for (int i = 0; i < 60; i++) begin
      a = 32'h4000 + ($urandom_range(0, 63) << 3) + $urandom_range(0, 7);
      tg = 4'($urandom_range(1, 15));
      dc = $urandom_range(0, 1) ? ((tg == 4'd15) ? 4'd1 : tg + 4'd1) : 4'd0;
      do_load(a, 3'($urandom_range(0, 7)), $urandom_range(0, 2), tg, dc, m);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
`ifdef DCACHE_STATS_EN
    checks++;
    if (miss_count !== 32'(exp_misses) || hit_count !== 32'(exp_hits)) begin
      errors++;
      $display("FAIL rand_stats: miss=%0d hit=%0d want %0d %0d",
               miss_count, hit_count, exp_misses, exp_hits);
    end
`endif
  endtask

  initial begin
    clock = 0;
    reset = 0;
    rd_cache = 0;
    addr = 0;
    mem_size = 0;
    mem2proc_response = 0;
    mem2proc_tag = 0;
    mem2proc_data = 0;
    clear_model();
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_reject();
    test_eviction();
    test_reset_wait();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
